// File: rtl/gf_pkg.sv
// rtl/gf_pkg.sv - shared GF(16) constants, nibble type and arithmetic helpers
//
// Shared by the composite-field stages of the AES S-box datapath.
//   GF16_POLY      : field polynomial x^4 + x + 1
//   LAMBDA_DEFAULT : lambda of the extension polynomial y^2 + y + lambda
//   gf16_t         : one GF(16) element (4-bit nibble)
//   gf16_mul       : product of two GF(16) elements
//   gf16_sq        : square of a GF(16) element
package gf_pkg;

  localparam logic [4:0] GF16_POLY      = 5'b10011;
  localparam logic [3:0] LAMBDA_DEFAULT = 4'hC;

  typedef logic [3:0] gf16_t;

  // Shift-and-add multiply; the multiplicand is reduced by x^4 = x + 1
  // every time it is shifted past bit 3.
  function automatic gf16_t gf16_mul(input gf16_t a, input gf16_t b);
    gf16_t acc;
    gf16_t x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x[3] ? ({x[2:0], 1'b0} ^ GF16_POLY[3:0]) : {x[2:0], 1'b0};
    end
    return acc;
  endfunction

  // Squaring is linear in characteristic 2:
  // a^2 = a0 + a1 x^2 + a2 x^4 + a3 x^6, with x^4 = x + 1, x^6 = x^3 + x^2.
  function automatic gf16_t gf16_sq(input gf16_t a);
    return {a[3], a[1] ^ a[3], a[2], a[0] ^ a[2]};
  endfunction

endpackage

// File: rtl/gf16_inv.sv
// rtl/gf16_inv.sv - combinational GF(16) multiplicative inverse lookup
//
// Ports:
//   a : element to invert
//   y : inverse of a, with inv(0) defined as 0
module gf16_inv
  import gf_pkg::*;
(
  input  gf16_t a,
  output gf16_t y
);

  always_comb begin
    y = 4'h0;
    case (a)
      4'h0: y = 4'h0;
      4'h1: y = 4'h1;
      4'h2: y = 4'h9;
      4'h3: y = 4'hE;
      4'h4: y = 4'hD;
      4'h5: y = 4'hB;
      4'h6: y = 4'h7;
      4'h7: y = 4'h6;
      4'h8: y = 4'hF;
      4'h9: y = 4'h2;
      4'hA: y = 4'hC;
      4'hB: y = 4'h5;
      4'hC: y = 4'hA;
      4'hD: y = 4'h4;
      4'hE: y = 4'h3;
      4'hF: y = 4'h8;
      default: y = 4'h0;
    endcase
  end

endmodule

// File: rtl/gf16sq_inv_pipe.sv
// rtl/gf16sq_inv_pipe.sv - 3-stage pipelined inverter in GF((2^4)^2)
//
// Inverts p*y + q over y^2 + y + LAMBDA:
//   d = LAMBDA*p^2 + p*q + q^2,  p' = p/d,  q' = (p+q)/d,  inv(0) = 0.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake
//   in_p, in_q          : element high (y) and low coefficients
//   out_valid/out_ready : output handshake
//   out_p, out_q        : inverse high and low coefficients
module gf16sq_inv_pipe
  import gf_pkg::*;
#(
  parameter gf16_t LAMBDA = LAMBDA_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_p,
  input  logic [3:0] in_q,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_p,
  output logic [3:0] out_q
);

  logic  v1, v2, v3;
  gf16_t p1, q1, d1;
  gf16_t p2, q2, dinv2;
  gf16_t p3, q3;
  gf16_t dinv;
  logic  stall;
  logic  en;

  // A held result freezes the whole pipeline; nothing may move past it.
  assign stall    = v3 & ~out_ready;
  assign en       = ~stall;
  assign in_ready = en;

  gf16_inv u_inv (
    .a (d1),
    .y (dinv)
  );

  // Data registers load unconditionally while enabled; a bubble just
  // carries stale data alongside its cleared valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      p1    <= '0;
      q1    <= '0;
      d1    <= '0;
      p2    <= '0;
      q2    <= '0;
      dinv2 <= '0;
      p3    <= '0;
      q3    <= '0;
    end else if (en) begin
      v1    <= in_valid;
      p1    <= in_p;
      q1    <= in_q;
      d1    <= gf16_mul(LAMBDA, gf16_sq(in_p)) ^ gf16_mul(in_p, in_q) ^ gf16_sq(in_q);
      v2    <= v1;
      p2    <= p1;
      q2    <= q1;
      dinv2 <= dinv;
      v3    <= v2;
      p3    <= gf16_mul(p2, dinv2);
      q3    <= gf16_mul(p2 ^ q2, dinv2);
    end
  end

  assign out_valid = v3;
  assign out_p     = p3;
  assign out_q     = q3;

endmodule

// File: tb/tb_gf16sq_inv_pipe.sv
// tb/tb_gf16sq_inv_pipe.sv - self-checking bench for gf16sq_inv_pipe
module tb_gf16sq_inv_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_p;
  logic [3:0] in_q;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_p;
  logic [3:0] out_q;

  always #5 clk = ~clk;

  gf16sq_inv_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .in_q      (in_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_q     (out_q)
  );

  typedef struct {
    logic [3:0] p;
    logic [3:0] q;
    bit         has_exp;
    logic [3:0] ep;
    logic [3:0] eq;
    int         acc;
    bit         chk_lat;
  } sb_t;

  typedef struct {
    logic [3:0] p;
    logic [3:0] q;
    logic [3:0] ep;
    logic [3:0] eq;
  } vec_t;

  sb_t  sb[$];
  sb_t  mon_e;
  vec_t vecs[6];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   stall_seen = 0;
  bit   lat_en = 1'b1;
  bit   prev_stall = 1'b0;
  logic [3:0] prev_p, prev_q;
  logic [3:0] c0, c1;

  always @(posedge clk) cyc <= cyc + 1;

  // Polynomial product followed by reduction mod x^4 + x + 1.
  function automatic logic [3:0] mul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 4; i++)
      if (b[i]) r = r ^ (8'(a) << i);
    for (int k = 7; k >= 4; k--)
      if (r[k]) r = r ^ (8'h13 << (k - 4));
    return r[3:0];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] p, input logic [3:0] q, input bit he,
                      input logic [3:0] ep, input logic [3:0] eq);
    int  t;
    sb_t e;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_p     = p;
    in_q     = q;
    #1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck at 0 for element %0h,%0h", p, q);
    end
    e.p = p; e.q = q; e.has_exp = he; e.ep = ep; e.eq = eq;
    e.acc = cyc; e.chk_lat = lat_en;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check(name, sb.size(), 0);
  endtask

  // Output monitor: samples after the driver has settled each negedge.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_p", out_p, prev_p);
        check("hold_q", out_q, prev_q);
      end
      if (out_valid && !out_ready) begin
        stall_seen++;
        check("stall_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_output: got %0h,%0h with nothing outstanding", out_p, out_q);
        end else begin
          mon_e = sb.pop_front();
          // (p*y+q)(p'*y+q') reduced with y^2 = y + lambda
          c1 = mul(mon_e.p, out_p) ^ mul(mon_e.p, out_q) ^ mul(mon_e.q, out_p);
          c0 = mul(mon_e.q, out_q) ^ mul(4'hC, mul(mon_e.p, out_p));
          if (mon_e.p == 4'h0 && mon_e.q == 4'h0)
            check("zero_out", {out_p, out_q}, 8'h00);
          else
            check("inv_product", {c1, c0}, 8'h01);
          if (mon_e.has_exp)
            check("vec_out", {out_p, out_q}, {mon_e.ep, mon_e.eq});
          if (mon_e.chk_lat)
            check("latency", cyc - mon_e.acc, 3);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_p     = out_p;
      prev_q     = out_q;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    vecs[0] = '{4'h0, 4'h1, 4'h0, 4'h1};
    vecs[1] = '{4'h0, 4'h0, 4'h0, 4'h0};
    vecs[2] = '{4'h1, 4'h0, 4'hA, 4'hA};
    vecs[3] = '{4'h1, 4'h1, 4'hA, 4'h0};
    vecs[4] = '{4'h0, 4'h2, 4'h0, 4'h9};
    vecs[5] = '{4'h0, 4'hC, 4'h0, 4'hA};

    // Reset with a valid input present
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_p      = 4'h5;
    in_q      = 4'h3;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_p", out_p, 0);
    check("reset_out_q", out_q, 0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1);

    // Directed single elements
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].p, vecs[i].q, 1'b1, vecs[i].ep, vecs[i].eq);
      repeat (5) @(negedge clk);
    end
    drain("directed_drain");

    // All 256 elements back-to-back
    for (int i = 0; i < 256; i++)
      send(4'(i >> 4), 4'(i), 1'b0, 4'h0, 4'h0);
    drain("stream_drain");

    // Back-pressure mid-stream
    lat_en = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(4'(i + 3), 4'(5 * i + 1), 1'b0, 4'h0, 4'h0);
      end
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    check("bp_stall_seen", (stall_seen > 0) ? 1 : 0, 1);
    lat_en = 1'b1;

    // Bubbles: one idle cycle between elements
    for (int i = 0; i < 8; i++) begin
      send(4'(2 * i + 1), 4'(15 - i), 1'b0, 4'h0, 4'h0);
      @(negedge clk);
    end
    drain("bubble_drain");

    // Mid-flight reset discards two in-flight elements
    send(4'h1, 4'h2, 1'b0, 4'h0, 4'h0);
    send(4'h3, 4'h4, 1'b0, 4'h0, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #2;
    check("midreset_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      check("post_reset_quiet", out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gf16sq_inv_pipe.md
Name: gf16sq_inv_pipe

Overview:
- Pipelined multiplicative inverter in the composite field GF((2^4)^2), the nonlinear core of the AES S-box datapath.
- Consumes an element (p·y + q) from the GF(256)→GF(16^2) isomorphism stage and produces its inverse (p', q').
- Output feeds gf16_to_gf256 directly.
- 3-stage pipeline with valid/ready flow control so it can sit in a back-pressured round datapath.

Parameters:
- LAMBDA, 4'hC, constant λ of the extension polynomial y^2 + y + λ over GF(16).
- GF(16) polynomial is fixed at x^4 + x + 1.

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input element valid
- in_ready  out  1  block can accept input this cycle
- in_p  in  4  high coefficient (y term)
- in_q  in  4  low coefficient
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_p  out  4  inverse high coefficient, wired to gf16_to_gf256 p
- out_q  out  4  inverse low coefficient, wired to gf16_to_gf256 q

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset state: all stage valid bits = 0; out_valid = 0; out_p = out_q = 0; in_ready = 1 once rst deasserts.
- Math, all GF(16) ops mod x^4 + x + 1:
  - d = λ·p² ⊕ p·q ⊕ q²
  - p' = p·d⁻¹
  - q' = (p ⊕ q)·d⁻¹
  - inv(0) is defined as 0, so input (0,0) gives (0,0).
- Stage 1: register p, q, d, v1.
- Stage 2: register p, q, dinv = inv(d), v2.
- Stage 3: register p', q', v3; v3 drives out_valid.
- Latency is exactly 3 cycles from input handshake to out_valid when out_ready is held 1.
- Throughput is 1 element per cycle.
- Stall: stall = out_valid & ~out_ready.
  - While stall is asserted, all stages hold (global enable = ~stall).
  - in_ready = ~stall, combinational from out_valid and out_ready.
- Input handshake: accepted only when in_valid & in_ready.
  - Bubbles (in_valid = 0) propagate as v = 0; data registers of a bubble stage may hold stale values.
- Output data stays stable while out_valid & ~out_ready; no output is dropped or duplicated.
- Simultaneous output drain and input accept in the same cycle is legal.
- Reset asserted mid-operation: all in-flight elements are discarded immediately; no output appears after deassert until new input is accepted.
- No combinational path from in_* to out_*.

Decomposition:
- Shared package gf_pkg:
  - GF16_POLY = 5'b10011
  - default LAMBDA = 4'hC
  - gf16 nibble typedef
  - functions gf16_mul and gf16_sq, shared with the other composite-field stages
- Sub-module gf16_inv: combinational 16-entry inverse LUT, with inv(0) = 0; instantiated in stage 2.

Test Plan:
- Reset check: assert rst with in_valid = 1 → out_valid = 0, out_p/out_q = 0; in_ready = 1 after deassert.
- Single elements, out_ready = 1; each result appears exactly 3 cycles after accept:
  - (p,q) = (0,1) → (0,1)
  - (0,0) → (0,0)
  - (1,0) → (A,A)
  - (1,1) → (A,0)
- Exhaustive streaming: all 256 inputs back-to-back → 256 outputs in order; each satisfies (p·y+q)(p'·y+q') = 1, except 0 → 0; a model using y² = y + λ checks the product.
- Back-pressure: stream 8 elements, drop out_ready for 5 cycles mid-stream → in_ready = 0 during stall, output held stable, no loss or duplication.
- Bubbles: alternate in_valid 1/0 → outputs spaced identically, latency still 3.
- Mid-flight reset: accept 2 elements, pulse rst at cycle 1 → no output for either element.
